// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned DEF_N_REQ          = 4;
    localparam int unsigned DEF_LAUNCH_TIMEOUT = 1024;
    localparam int unsigned BYTE_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection: first requesting index at or above pointer, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  pointer,
    output logic             valid,
    output logic [ID_W-1:0]  winner
);

    // Index that sits 'offset' places after 'base', modulo N_REQ.
    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return ID_W'(sum % int'(N_REQ));
    endfunction

    // Scan from the farthest offset back to the pointer so the nearest request wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (req[rot_idx(pointer, k)]) begin
                valid  = 1'b1;
                winner = rot_idx(pointer, k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters with round-robin grants.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ          = DEF_N_REQ,
    parameter int unsigned LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [BYTE_W*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       err,
    output logic [$clog2(N_REQ)-1:0]   active_id,
    output logic [BYTE_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(LAUNCH_TIMEOUT + 1);

    arb_state_e         state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_start_q, tx_start_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_id;
    logic [BYTE_W-1:0]  pick_data;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req     (req),
        .pointer (ptr_q),
        .valid   (pick_valid),
        .winner  (pick_id)
    );

    // Byte offered by the current round-robin winner.
    always_comb begin
        pick_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (pick_id == ID_W'(i)) begin
                pick_data = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state and output decode; pulses default low, held values default to current.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        active_id_d = active_id_q;
        tx_data_d   = tx_data_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = 1'b0;
        tx_start_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A busy transmitter (possibly a frame orphaned by reset) blocks all grants.
                if (!tx_busy && pick_valid) begin
                    gnt_d       = N_REQ'(1) << pick_id;
                    tx_data_d   = pick_data;
                    active_id_d = pick_id;
                    ptr_d       = (pick_id == ID_W'(N_REQ - 1)) ? '0 : pick_id + ID_W'(1);
                    cnt_d       = '0;
                    tx_start_d  = 1'b1;
                    state_d     = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Start is held until the transmitter's baud tick picks it up.
                if (tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_inc == CNT_W'(LAUNCH_TIMEOUT)) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d      = cnt_inc;
                    tx_start_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d  = N_REQ'(1) << active_id_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            active_id_q <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            active_id_q <= active_id_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign active_id = active_id_q;
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;

endmodule
